// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - per-key synchroniser, debouncer and press/release/repeat pulse generator
module key_conditioner #(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [NUM_KEYS-1:0] Key_N,
  output logic [NUM_KEYS-1:0] Pressed,
  output logic [NUM_KEYS-1:0] Press_Pulse,
  output logic [NUM_KEYS-1:0] Release_Pulse,
  output logic [NUM_KEYS-1:0] Repeat_Pulse,
  output logic [NUM_KEYS-1:0] Action_Pulse
);

  localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX) + 1;

  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } key_state_t;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    logic             sync1, sync2, s;
    key_state_t       state_q, state_d;
    logic [DEB_W-1:0] deb_q, deb_d;
    logic [RPT_W-1:0] rpt_q, rpt_d, rpt_inc, rpt_target;
    logic             first_q, first_d;
    logic             pressed_q, pressed_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             repeat_q, repeat_d;

    // Sync flops idle at 1 so a reset never looks like a press by itself
    always_ff @(posedge Clk) begin
      if (Reset) begin
        sync1 <= 1'b1;
        sync2 <= 1'b1;
      end else begin
        sync1 <= Key_N[i];
        sync2 <= sync1;
      end
    end

    assign s          = ~sync2;
    assign rpt_inc    = rpt_q + RPT_W'(1);
    assign rpt_target = first_q ? RPT_FIRST : RPT_NEXT;

    always_ff @(posedge Clk) begin
      if (Reset) begin
        state_q   <= RELEASED;
        deb_q     <= '0;
        rpt_q     <= '0;
        first_q   <= 1'b0;
        pressed_q <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        state_q   <= state_d;
        deb_q     <= deb_d;
        rpt_q     <= rpt_d;
        first_q   <= first_d;
        pressed_q <= pressed_d;
        press_q   <= press_d;
        release_q <= release_d;
        repeat_q  <= repeat_d;
      end
    end

    always_comb begin
      state_d   = state_q;
      deb_d     = deb_q;
      rpt_d     = rpt_q;
      first_d   = first_q;
      pressed_d = pressed_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      repeat_d  = 1'b0;
      unique case (state_q)
        RELEASED: begin
          if (s) begin
            state_d = PRESS_CHK;
            deb_d   = '0;
          end
        end
        PRESS_CHK: begin
          if (!s) begin
            state_d = RELEASED;
          end else if (deb_q == DEB_LAST) begin
            state_d   = HELD;
            pressed_d = 1'b1;
            press_d   = 1'b1;
            rpt_d     = '0;
            first_d   = 1'b1;
          end else begin
            deb_d = deb_q + DEB_W'(1);
          end
        end
        HELD: begin
          // rpt_q is left untouched on the way out so a rejected glitch resumes the cadence
          if (!s) begin
            state_d = RELEASE_CHK;
            deb_d   = '0;
          end else if ((REPEAT_EN != 0) && (rpt_inc == rpt_target)) begin
            repeat_d = 1'b1;
            rpt_d    = '0;
            first_d  = 1'b0;
          end else begin
            rpt_d = rpt_inc;
          end
        end
        RELEASE_CHK: begin
          if (s) begin
            state_d = HELD;
          end else if (deb_q == DEB_LAST) begin
            state_d   = RELEASED;
            pressed_d = 1'b0;
            release_d = 1'b1;
          end else begin
            deb_d = deb_q + DEB_W'(1);
          end
        end
        default: state_d = RELEASED;
      endcase
    end

    assign Pressed[i]       = pressed_q;
    assign Press_Pulse[i]   = press_q;
    assign Release_Pulse[i] = release_q;
    assign Repeat_Pulse[i]  = repeat_q;
    assign Action_Pulse[i]  = press_q | repeat_q;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - scoreboard bench for key_conditioner against a run-length key model
module tb_key_conditioner;

  localparam int NK  = 2;
  localparam int DEB = 4;
  localparam int RD  = 6;
  localparam int RP  = 3;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic [NK-1:0] Key_N = '0;
  logic [NK-1:0] Pressed, Press_Pulse, Release_Pulse, Repeat_Pulse, Action_Pulse;

  key_conditioner #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Key_N(Key_N),
    .Pressed(Pressed), .Press_Pulse(Press_Pulse), .Release_Pulse(Release_Pulse),
    .Repeat_Pulse(Repeat_Pulse), .Action_Pulse(Action_Pulse)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [NK-1:0] pressed, press, rel, rpt, action;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  // Model: a key flips once DEB+1 consecutive synchronised samples disagree with its level;
  // repeats count only samples taken while the key is steadily held.
  bit m_d1[NK], m_d2[NK], m_level[NK], m_first[NK];
  int m_run[NK], m_hold[NK];

  function automatic exp_t model_step(input bit rst, input logic [NK-1:0] kn);
    exp_t e;
    bit   s;
    e = '{default: '0};
    for (int i = 0; i < NK; i++) begin
      if (rst) begin
        m_d1[i] = 1; m_d2[i] = 1; m_level[i] = 0; m_first[i] = 0;
        m_run[i] = 0; m_hold[i] = 0;
      end else begin
        s = !m_d2[i];
        m_d2[i] = m_d1[i];
        m_d1[i] = kn[i];
        if (s != m_level[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB + 1) begin
            m_level[i] = s;
            m_run[i]   = 0;
            if (s) begin
              e.press[i] = 1; m_hold[i] = 0; m_first[i] = 1;
            end else begin
              e.rel[i] = 1;
            end
          end
        end else begin
          if (m_level[i] && m_run[i] == 0) begin
            m_hold[i]++;
            if (m_hold[i] == (m_first[i] ? RD : RP)) begin
              e.rpt[i] = 1; m_hold[i] = 0; m_first[i] = 0;
            end
          end
          m_run[i] = 0;
        end
      end
      e.pressed[i] = m_level[i];
      e.action[i]  = e.press[i] | e.rpt[i];
    end
    return e;
  endfunction

  task automatic cyc(input bit rst, input logic [NK-1:0] kn);
    @(negedge Clk);
    Reset = rst;
    Key_N = kn;
    exp_q.push_back(model_step(rst, kn));
  endtask

  task automatic hold(input bit rst, input logic [NK-1:0] kn, input int n);
    for (int k = 0; k < n; k++) cyc(rst, kn);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      cycle++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (Pressed !== e.pressed || Press_Pulse !== e.press || Release_Pulse !== e.rel ||
            Repeat_Pulse !== e.rpt || Action_Pulse !== e.action) begin
          errors++;
          $display("FAIL outputs cycle %0d: got prs=%b pp=%b rp=%b rep=%b act=%b want prs=%b pp=%b rp=%b rep=%b act=%b",
                   cycle, Pressed, Press_Pulse, Release_Pulse, Repeat_Pulse, Action_Pulse,
                   e.pressed, e.press, e.rel, e.rpt, e.action);
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [NK-1:0] kn;
    int            left[NK];
    hold(1, 2'b00, 2);
    hold(0, 2'b00, 12);
    hold(0, 2'b11, 12);
    hold(0, 2'b10, 32);
    hold(0, 2'b11, 2);
    hold(0, 2'b10, 20);
    hold(0, 2'b11, 12);
    hold(0, 2'b10, 3);
    hold(0, 2'b11, 8);
    hold(0, 2'b10, 5);
    hold(1, 2'b10, 2);
    hold(0, 2'b10, 12);
    hold(0, 2'b11, 12);
    kn = 2'b11;
    left = '{0, 0};
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NK; i++) begin
        if (left[i] == 0) begin
          kn[i] = ~kn[i];
          left[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 25);
        end
        left[i]--;
      end
      if ($urandom_range(0, 399) == 0) hold(1, kn, $urandom_range(1, 2));
      else cyc(0, kn);
    end
    hold(0, 2'b11, 3);
    @(negedge Clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Conditions the raw active-low push-buttons (Reset_Clear, Run_Accumulate and future keys) before they reach the run-once control and register logic of the adder/accumulator datapath.
- Per key, it performs:
  - 2-FF synchronisation,
  - counter-based debounce,
  - clean level output,
  - single-cycle press and release pulses,
  - optional hold-to-repeat pulses, so a held Run key can accumulate repeatedly.
- All keys are independent; one instance serves the whole button bank.

Parameters:
- NUM_KEYS, 2: number of independent key channels.
- DEBOUNCE_CYCLES, 500000: cycles the synchronised input must be stable before a transition is accepted (10 ms at 50 MHz); legal range ≥ 1.
- REPEAT_EN, 0: 1 enables Repeat_Pulse generation.
- REPEAT_DELAY, 25000000: cycles from Press_Pulse to the first Repeat_Pulse; legal range ≥ 1.
- REPEAT_PERIOD, 5000000: cycles between subsequent Repeat_Pulses; legal range ≥ 1.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- Key_N  in  NUM_KEYS  raw asynchronous keys, active-low (0 = pressed).
- Pressed  out  NUM_KEYS  debounced level, active-high.
- Press_Pulse  out  NUM_KEYS  one-cycle pulse on accepted press.
- Release_Pulse  out  NUM_KEYS  one-cycle pulse on accepted release.
- Repeat_Pulse  out  NUM_KEYS  one-cycle pulse per repeat interval while held.
- Action_Pulse  out  NUM_KEYS  Press_Pulse | Repeat_Pulse, bitwise.

Behaviour:
- Clock and reset:
  - One clock (Clk); reset is synchronous and active-high (Reset).
  - All state updates on the Clk rising edge.
- Reset values:
  - Sync flops = 1 (released).
  - All states RELEASED; all counters = 0.
  - Pressed, Press_Pulse, Release_Pulse, Repeat_Pulse, Action_Pulse = 0.
  - Reset has priority over every transition.
  - Reset mid-debounce or mid-hold discards all progress.
  - A key still held when Reset deasserts is debounced as a fresh press and produces a Press_Pulse.
- Synchronisation:
  - Key_N[i] → sync1 → sync2.
  - s = ~sync2 (1 = pressed).
  - The state machine sees only s.
- Per-key state machine (registered outputs, deb_cnt width $clog2(DEBOUNCE_CYCLES)+1):
  - RELEASED:
    - Pressed = 0.
    - s = 1 → PRESS_CHK with deb_cnt = 0.
  - PRESS_CHK:
    - s = 0 → RELEASED (bounce rejected, no pulse).
    - Else if deb_cnt == DEBOUNCE_CYCLES-1 → HELD; on that edge Pressed ← 1, Press_Pulse ← 1, rpt_cnt ← 0, first_rpt ← 1.
    - Else deb_cnt++.
  - HELD:
    - s = 0 → RELEASE_CHK with deb_cnt = 0; rpt_cnt is frozen.
    - Else rpt_cnt++.
    - If REPEAT_EN, Repeat_Pulse ← 1 when rpt_cnt reaches the current target: REPEAT_DELAY if first_rpt, else REPEAT_PERIOD. On that edge rpt_cnt ← 0 and first_rpt ← 0.
  - RELEASE_CHK:
    - Pressed remains 1.
    - s = 1 → HELD (glitch rejected); rpt_cnt resumes from its frozen value.
    - Else if deb_cnt == DEBOUNCE_CYCLES-1 → RELEASED with Pressed ← 0, Release_Pulse ← 1.
    - Else deb_cnt++.
    - Repeat_Pulse is never asserted in this state.
- Pulse rules:
  - Each pulse is high for exactly one cycle.
  - Press and Repeat are never high in the same cycle.
  - Release and Repeat are never high in the same cycle.
- Latency:
  - Key_N held stable low from before edge k: Pressed and Press_Pulse are high after edge k+DEBOUNCE_CYCLES+2 (2 sync + 1 state entry + DEBOUNCE_CYCLES-1 counts + 1 transition).
  - Release is symmetric.
- Repeat timing, uninterrupted hold: Repeat_Pulse occurs REPEAT_DELAY cycles after the Press_Pulse cycle, then every REPEAT_PERIOD cycles.
- REPEAT_EN = 0: Repeat_Pulse tied 0; rpt_cnt may be optimised away.
- Channels share no state; simultaneous events on different keys are fully independent.

Test Plan (NUM_KEYS=2, DEBOUNCE_CYCLES=4, REPEAT_EN=1, REPEAT_DELAY=6, REPEAT_PERIOD=3):
- Reset for 2 cycles with Key_N = 2'b00 → all outputs 0 during reset. Press_Pulse = 2'b11 exactly 7 edges after Reset deasserts, one cycle wide.
- Key_N[0] falls and stays low, Key_N[1] high → Press_Pulse[0] high on edge 7 only; Pressed[0] = 1 from edge 7; channel 1 outputs remain 0.
- Key_N[0] low for 3 cycles, then high → no Press_Pulse, Pressed[0] stays 0, state returns to RELEASED.
- Key_N[0] held for 20 cycles after Press_Pulse → Repeat_Pulse[0] at +6, +9, +12, +15, +18 cycles after Press_Pulse; Action_Pulse[0] at the press and each repeat.
- While HELD, Key_N[0] high for 2 cycles, then low → no Release_Pulse, Pressed stays 1, repeat cadence shifted by exactly the frozen cycles. Later, Key_N[0] high steadily → Release_Pulse[0] 7 edges after the rise, Pressed[0] = 0.
- Assert Reset while channel 0 is in PRESS_CHK at deb_cnt = 2 → no pulse; after release of Reset with the key still low, a full 7-cycle debounce precedes Press_Pulse[0].
